// File: rtl/warp_issue_arbiter_if.sv
// Bundle between the per-warp instruction buffers, the execute pipeline and the issue arbiter.
// Handshake: grant_valid is only raised while the pipeline can accept (stall=0), and it is consumed by the next posedge; done_valid is a one-cycle completion pulse with no backpressure.
interface warp_issue_arbiter_if #(
  parameter int NUM_WARPS     = 4,
  parameter int WARP_ID_WIDTH = 2
);
  logic [NUM_WARPS-1:0]     req;
  logic                     stall;
  logic                     done_valid;
  logic [WARP_ID_WIDTH-1:0] done_id;
  logic                     grant_valid;
  logic [WARP_ID_WIDTH-1:0] grant_id;
  logic [NUM_WARPS-1:0]     grant_vec;
  logic [NUM_WARPS-1:0]     full_vec;
  logic                     idle;
  logic                     err;
  logic [WARP_ID_WIDTH-1:0] ptr;

  modport master (
    output req, stall, done_valid, done_id,
    input  grant_valid, grant_id, grant_vec, full_vec, idle, err, ptr
  );

  modport slave (
    input  req, stall, done_valid, done_id,
    output grant_valid, grant_id, grant_vec, full_vec, idle, err, ptr
  );
endinterface

// File: rtl/warp_issue_arbiter.sv
// Round-robin issue arbiter with per-warp in-flight limits; ptr is exported on the
// interface so the rotation state can be observed directly.
module warp_issue_arbiter #(
  parameter int NUM_WARPS     = 4,
  parameter int WARP_ID_WIDTH = 2,
  parameter int CNT_WIDTH     = 3,
  parameter int MAX_INFLIGHT  = 4
) (
  input logic                 clk,
  input logic                 rst,
  warp_issue_arbiter_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0]     MAX_CNT = CNT_WIDTH'(MAX_INFLIGHT);
  localparam logic [WARP_ID_WIDTH-1:0] LAST_ID = WARP_ID_WIDTH'(NUM_WARPS - 1);

  logic [CNT_WIDTH-1:0]     cnt [NUM_WARPS];
  logic [WARP_ID_WIDTH-1:0] ptr;
  logic                     err_q;

  logic [NUM_WARPS-1:0]     eligible;
  logic [NUM_WARPS-1:0]     inc_vec;
  logic [NUM_WARPS-1:0]     dec_vec;
  logic [NUM_WARPS-1:0]     full_vec;
  logic                     any_eligible;
  logic                     grant_valid;
  logic                     found;
  logic                     idle;
  logic                     done_in_range;
  logic                     done_underflow;
  logic [WARP_ID_WIDTH-1:0] sel_id;
  logic [WARP_ID_WIDTH-1:0] ptr_next;
  int unsigned              idx;

  // Eligibility looks only at registered counts, so a same-cycle completion
  // cannot unblock a full warp.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      eligible[i] = bus.req[i] && (cnt[i] < MAX_CNT);
    end
  end

  assign any_eligible = |eligible;

  always_comb begin
    sel_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_WARPS; k++) begin
      idx = (int'(ptr) + k) % NUM_WARPS;
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        sel_id = WARP_ID_WIDTH'(idx);
      end
    end
  end

  // Grants are held off while reset is asserted so outputs match the reset state.
  assign grant_valid   = any_eligible && !bus.stall && rst;
  assign ptr_next      = (sel_id == LAST_ID) ? '0 : sel_id + 1'b1;
  assign done_in_range = int'(bus.done_id) < NUM_WARPS;

  always_comb begin
    inc_vec        = '0;
    dec_vec        = '0;
    full_vec       = '0;
    idle           = 1'b1;
    done_underflow = 1'b0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      inc_vec[i]  = grant_valid && (int'(sel_id) == i);
      full_vec[i] = (cnt[i] == MAX_CNT);
      if (cnt[i] != '0) idle = 1'b0;
      if (bus.done_valid && (int'(bus.done_id) == i)) begin
        if (cnt[i] == '0) done_underflow = 1'b1;
        else              dec_vec[i]     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_WARPS; i++) cnt[i] <= '0;
      ptr   <= '0;
      err_q <= 1'b0;
    end else begin
      // Grant and completion on the same warp cancel out.
      for (int i = 0; i < NUM_WARPS; i++) begin
        if (inc_vec[i] && !dec_vec[i])      cnt[i] <= cnt[i] + 1'b1;
        else if (dec_vec[i] && !inc_vec[i]) cnt[i] <= cnt[i] - 1'b1;
      end
      if (grant_valid) ptr <= ptr_next;
      if (bus.done_valid && (!done_in_range || done_underflow)) err_q <= 1'b1;
    end
  end

  assign bus.grant_valid = grant_valid;
  assign bus.grant_id    = grant_valid ? sel_id : '0;
  assign bus.grant_vec   = inc_vec;
  assign bus.full_vec    = full_vec;
  assign bus.idle        = idle;
  assign bus.err         = err_q;
  assign bus.ptr         = ptr;

endmodule

// File: tb/tb_warp_issue_arbiter.sv
// Bench for warp_issue_arbiter: directed scenarios plus random traffic against a
// counter/queue reference model; a monitor compares every cycle's outputs.
module tb_warp_issue_arbiter;
  localparam int NW   = 4;
  localparam int IDW  = 2;
  localparam int CW   = 3;
  localparam int MAXI = 4;
  localparam int W    = 1 + IDW + NW + NW + 1 + 1 + IDW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   rst_req = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];

  int cnt_m[NW];
  int ptr_m;
  bit err_m;

  always #5 clk = ~clk;

  warp_issue_arbiter_if #(.NUM_WARPS(NW), .WARP_ID_WIDTH(IDW)) bus ();

  warp_issue_arbiter #(
    .NUM_WARPS(NW), .WARP_ID_WIDTH(IDW), .CNT_WIDTH(CW), .MAX_INFLIGHT(MAXI)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [W-1:0] dut_out();
    return {bus.grant_valid, bus.grant_id, bus.grant_vec, bus.full_vec,
            bus.idle, bus.err, bus.ptr};
  endfunction

  function automatic void show(input string name, input logic [W-1:0] a, input logic [W-1:0] e);
    $display("FAIL %s: got gv=%0d id=%0d vec=%b full=%b idle=%0d err=%0d ptr=%0d, expected gv=%0d id=%0d vec=%b full=%b idle=%0d err=%0d ptr=%0d",
             name, a[14], a[13:12], a[11:8], a[7:4], a[3], a[2], a[1:0],
             e[14], e[13:12], e[11:8], e[7:4], e[3], e[2], e[1:0]);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NW; i++) cnt_m[i] = 0;
    ptr_m = 0;
    err_m = 1'b0;
  endfunction

  // Drive one cycle of inputs, predict this cycle's outputs, then advance the model past the edge.
  task automatic drive(input logic [NW-1:0] r, input bit st, input bit dv, input int did);
    bit gv;
    int gid;
    logic [NW-1:0] gvec, full;
    bit idl;
    @(negedge clk);
    rst            = rst_req;
    bus.req        = r;
    bus.stall      = st;
    bus.done_valid = dv;
    bus.done_id    = IDW'(did);
    gv = 1'b0; gid = 0; gvec = '0; full = '0; idl = 1'b1;
    if (rst && !st) begin
      for (int k = 0; k < NW; k++) begin
        int w;
        w = (ptr_m + k) % NW;
        if (!gv && r[w] && cnt_m[w] < MAXI) begin
          gv = 1'b1;
          gid = w;
        end
      end
    end
    if (gv) gvec[gid] = 1'b1;
    for (int i = 0; i < NW; i++) begin
      full[i] = (cnt_m[i] == MAXI);
      if (cnt_m[i] != 0) idl = 1'b0;
    end
    exp_q.push_back({gv, IDW'(gid), gvec, full, idl, err_m, IDW'(ptr_m)});
    if (rst) begin
      bit dec;
      dec = 1'b0;
      if (dv) begin
        if (did >= NW || cnt_m[did] == 0) err_m = 1'b1;
        else dec = 1'b1;
      end
      if (dec) cnt_m[did] = cnt_m[did] - 1;
      if (gv) begin
        cnt_m[gid] = cnt_m[gid] + 1;
        ptr_m = (gid + 1) % NW;
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    logic [W-1:0] e;
    logic [W-1:0] a;
    e = {1'b0, {IDW{1'b0}}, {NW{1'b0}}, {NW{1'b0}}, 1'b1, 1'b0, {IDW{1'b0}}};
    a = dut_out();
    n_checks++;
    if (a !== e) begin
      n_fail++;
      show(name, a, e);
    end
  endtask

  // Reset lands between edges; outputs must clear before the next clock edge.
  task automatic async_reset_check();
    @(posedge clk);
    #2;
    rst     = 1'b0;
    rst_req = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
  endtask

  initial begin : monitor
    logic [W-1:0] e;
    logic [W-1:0] a;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = dut_out();
        n_checks++;
        if (a !== e) begin
          n_fail++;
          show("cycle_out", a, e);
        end
      end
    end
  end

  initial begin : stimulus
    bus.req        = '0;
    bus.stall      = 1'b0;
    bus.done_valid = 1'b0;
    bus.done_id    = '0;
    model_reset();
    #1 rst = 1'b0;
    #1 check_reset_outputs("reset_state");

    drive(4'b0000, 0, 0, 0);
    rst_req = 1'b1;

    // Full request set rotates 0,1,2,3, then drain.
    repeat (4) drive(4'b1111, 0, 0, 0);
    for (int w = 0; w < NW; w++) drive(4'b0000, 0, 1, w);

    // Warp 0 alone fills up, stays blocked on a same-cycle done, resumes next cycle.
    repeat (5) drive(4'b0001, 0, 0, 0);
    drive(4'b0001, 0, 1, 0);
    drive(4'b0001, 0, 0, 0);
    repeat (4) drive(4'b0000, 0, 1, 0);

    // Grant and done on warp 2 in the same cycle.
    drive(4'b0100, 0, 0, 0);
    drive(4'b0100, 0, 1, 2);
    drive(4'b0000, 0, 1, 2);
    drive(4'b0000, 0, 0, 0);

    // Stall freezes ptr at 2; release grants warp 3.
    drive(4'b0010, 0, 0, 0);
    repeat (3) drive(4'b1010, 1, 0, 0);
    drive(4'b1010, 0, 0, 0);
    drive(4'b0000, 0, 1, 1);
    drive(4'b0000, 0, 1, 3);

    // Underflow on warp 1 sets a sticky error.
    drive(4'b0000, 0, 1, 1);
    repeat (2) drive(4'b0000, 0, 0, 0);

    repeat (300) begin
      drive(NW'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
            bit'($urandom_range(0, 1)), int'($urandom_range(0, NW - 1)));
    end

    repeat (6) drive(4'b1111, 0, 0, 0);
    async_reset_check();
    drive(4'b1111, 0, 1, 2);
    rst_req = 1'b1;
    repeat (40) begin
      drive(NW'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0),
            bit'($urandom_range(0, 1)), int'($urandom_range(0, NW - 1)));
    end

    repeat (2) @(negedge clk);
    #5;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
